// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: serial line in, parallel byte and status out.
// UART_RX_PARITY_EN adds the parity_err status line.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (input rx, output data_out, output valid, output busy,
                  output frame_err, output parity_err);
  modport slave  (output rx, input data_out, input valid, input busy,
                  input frame_err, input parity_err);
`else
  modport master (input rx, output data_out, output valid, output busy,
                  output frame_err);
  modport slave  (output rx, input data_out, input valid, input busy,
                  input frame_err);
`endif
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined), centre sampling,
// start-glitch rejection, stop-bit framing check and break hold-off.
module uart_rx #(
  parameter int unsigned CLK_PER_BIT = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int unsigned CW        = $clog2(CLK_PER_BIT) + 1;
  localparam int unsigned HALF      = CLK_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          rx_meta;
  logic          rx_s;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          busy_q;
  logic          ferr_q;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
  logic          perr_q;
`endif

  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

  // Synchronizer, bit timing and frame FSM; pulse outputs default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end

        // Recheck the line at mid start bit so short glitches are dropped.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif

        // Stop-bit midpoint: deliver the byte or flag a framing error.
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
`ifdef UART_RX_PARITY_EN
            perr_q <= ^{shift_reg, par_bit};
`endif
            if (rx_s) begin
              data_q  <= shift_reg;
              valid_q <= 1'b1;
              state   <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q <= 1'b1;
              state  <= BRK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Hold off until the line returns high so a long low cannot retrigger.
        BRK: begin
          cnt <= '0;
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: serial frames driven on rx, outputs checked with
// immediate assertions against hand-computed values.
module tb_uart_rx;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  // Busy spans half a start bit plus every following bit up to the stop midpoint.
  localparam int BUSY_EXP = CPB / 2 + (NBITS - 1) * CPB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(.CLK_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int vcnt = 0, fcnt = 0, both = 0, bcnt = 0, pcnt = 0, pv = 0;
  logic [7:0] rxq[$];

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.valid) begin
      rxq.push_back(bus.data_out);
      vcnt++;
    end
    if (bus.frame_err) fcnt++;
    if (bus.valid && bus.frame_err) both++;
    if (bus.busy) bcnt++;
`ifdef UART_RX_PARITY_EN
    if (bus.parity_err) pcnt++;
    if (bus.parity_err && bus.valid) pv++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
    chk(tag, 32'(got), 32'(exp));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ pflip);
`endif
    send_bit(stop_b);
  endtask

  int v0, f0, b0, p0, pv0;

  initial begin
    rst    = 1'b1;
    bus.rx = 1'b0;
    tick(3);
    chk("rst_data_out", 32'(bus.data_out), 32'h00);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);

    // Line held low out of reset: one framing error, then parked in BREAK.
    rst = 1'b0;
    tick(12 * CPB);
    chk("held_low_ferr", 32'(fcnt), 32'd1);
    chk("held_low_valid", 32'(vcnt), 32'd0);
    chk("held_low_busy", 32'(bus.busy), 32'h1);
    tick(4 * CPB);
    chk("held_low_ferr_once", 32'(fcnt), 32'd1);
    bus.rx = 1'b1;
    tick(CPB);
    chk("held_low_release_busy", 32'(bus.busy), 32'h0);
    tick(CPB);

    // Single frame 0xA5.
    v0 = vcnt; f0 = fcnt; b0 = bcnt;
    send_byte(8'hA5, 1'b1, 1'b0);
    tick(2 * CPB);
    chk("a5_valid_count", 32'(vcnt - v0), 32'd1);
    chk_pop("a5_data", 8'hA5);
    chk("a5_no_ferr", 32'(fcnt - f0), 32'd0);
    chk("a5_busy_len_ok", 32'((bcnt - b0 >= BUSY_EXP - 2) && (bcnt - b0 <= BUSY_EXP + 2)), 32'd1);
    chk("a5_busy_idle", 32'(bus.busy), 32'h0);
    chk("a5_data_hold", 32'(bus.data_out), 32'hA5);

    // Back-to-back frames with no idle gap.
    v0 = vcnt;
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    tick(2 * CPB);
    chk("b2b_valid_count", 32'(vcnt - v0), 32'd4);
    chk_pop("b2b_0", 8'h00);
    chk_pop("b2b_1", 8'hFF);
    chk_pop("b2b_2", 8'h3C);
    chk_pop("b2b_3", 8'hC3);

    // Short low glitch while idle is rejected.
    v0 = vcnt; f0 = fcnt;
    bus.rx = 1'b0;
    tick(4);
    bus.rx = 1'b1;
    tick(CPB);
    chk("glitch_busy", 32'(bus.busy), 32'h0);
    tick(2 * CPB);
    chk("glitch_no_valid", 32'(vcnt - v0), 32'd0);
    chk("glitch_no_ferr", 32'(fcnt - f0), 32'd0);

    // Stop bit low, line held low: one framing error, data kept, then recovery.
    v0 = vcnt; f0 = fcnt;
    send_byte(8'h5A, 1'b0, 1'b0);
    tick(3 * CPB);
    chk("ferr_count", 32'(fcnt - f0), 32'd1);
    chk("ferr_no_valid", 32'(vcnt - v0), 32'd0);
    chk("ferr_data_kept", 32'(bus.data_out), 32'hC3);
    chk("ferr_break_busy", 32'(bus.busy), 32'h1);
    bus.rx = 1'b1;
    tick(2 * CPB);
    chk("ferr_recover_busy", 32'(bus.busy), 32'h0);
    send_byte(8'h11, 1'b1, 1'b0);
    tick(2 * CPB);
    chk("after_ferr_valid", 32'(vcnt - v0), 32'd1);
    chk_pop("after_ferr_data", 8'h11);

    // Reset in the middle of bit 4 of 0x96.
    v0 = vcnt; f0 = fcnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.rx = 1'b1;
    tick(CPB / 2);
    rst = 1'b1;
    tick(2);
    chk("midrst_data_out", 32'(bus.data_out), 32'h00);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_valid", 32'(bus.valid), 32'h0);
    chk("midrst_frame_err", 32'(bus.frame_err), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(3 * CPB);
    chk("midrst_no_valid", 32'(vcnt - v0), 32'd0);
    chk("midrst_no_ferr", 32'(fcnt - f0), 32'd0);
    send_byte(8'h69, 1'b1, 1'b0);
    tick(2 * CPB);
    chk("midrst_next_valid", 32'(vcnt - v0), 32'd1);
    chk_pop("midrst_next_data", 8'h69);

`ifdef UART_RX_PARITY_EN
    // Even parity: correct bit, then flipped bit.
    v0 = vcnt; p0 = pcnt; pv0 = pv;
    send_byte(8'h07, 1'b1, 1'b0);
    tick(2 * CPB);
    chk("par_ok_valid", 32'(vcnt - v0), 32'd1);
    chk("par_ok_no_perr", 32'(pcnt - p0), 32'd0);
    chk_pop("par_ok_data", 8'h07);
    send_byte(8'h07, 1'b1, 1'b1);
    tick(2 * CPB);
    chk("par_bad_valid", 32'(vcnt - v0), 32'd2);
    chk("par_bad_perr", 32'(pcnt - p0), 32'd1);
    chk("par_bad_with_valid", 32'(pv - pv0), 32'd1);
    chk_pop("par_bad_data", 8'h07);
`endif

    chk("valid_ferr_exclusive", 32'(both), 32'd0);
    chk("queue_drained", 32'(rxq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
